// File: rtl/drf_loader_pkg.sv
// Shared defaults, nibble framing constants and FSM encoding for the code loader.
package drf_loader_pkg;

  localparam int ADDR_W_DEF    = 9;
  localparam int WORD_W_DEF    = 16;
  localparam int NIB_W_DEF     = 4;
  localparam int COUNT_NIBS    = 3;
  localparam int NIBS_PER_WORD = 4;
  localparam int NIB_CNT_W     = $clog2(NIBS_PER_WORD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/nibble_assembler.sv
// Shifts host nibbles MS-first into a word, counts nibbles per word and keeps
// a running XOR checksum of the data nibbles.
module nibble_assembler
  import drf_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NIB_W  = NIB_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 cnt_clr_i,
  input  logic                 shift_i,
  input  logic                 csum_en_i,
  input  logic [NIB_W-1:0]     nibble_i,
  output logic [WORD_W-1:0]    word_nxt_o,
  output logic [NIB_CNT_W-1:0] nib_cnt_o,
  output logic                 word_complete_o,
  output logic [NIB_W-1:0]     csum_o
);

  logic [WORD_W-1:0]    shift_q, shift_d;
  logic [NIB_CNT_W-1:0] cnt_q, cnt_d;
  logic [NIB_W-1:0]     csum_q, csum_d;

  // Word value including the nibble being accepted this cycle.
  assign word_nxt_o      = {shift_q[WORD_W-NIB_W-1:0], nibble_i};
  assign word_complete_o = shift_i && (cnt_q == NIB_CNT_W'(NIBS_PER_WORD - 1));
  assign nib_cnt_o       = cnt_q;
  assign csum_o          = csum_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
      csum_d  = '0;
    end else begin
      if (shift_i) begin
        shift_d = word_nxt_o;
        cnt_d   = word_complete_o ? '0 : cnt_q + 1'b1;
        if (csum_en_i) csum_d = csum_q ^ nibble_i;
      end
      if (cnt_clr_i) cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: rtl/code_loader.sv
// Loads a checksummed program image from a nibble-wide host link into code memory.
// state | meaning
// IDLE  | after reset, waiting for in_start; CPU held
// COUNT | receiving the 3-nibble word count
// DATA  | receiving the 4 nibbles of the next word
// WRITE | one-cycle write strobe to code memory
// CHECK | receiving the checksum nibble
// DONE  | verified load, CPU released
// ERROR | bad count or checksum; CPU held
module code_loader
  import drf_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int NIB_W  = NIB_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_start,
  input  logic [NIB_W-1:0]  in_nibble,
  input  logic              in_nibble_valid,
  output logic              out_nibble_ready,
  output logic [ADDR_W-1:0] out_code_addr,
  output logic [WORD_W-1:0] out_code_data,
  output logic              out_code_wr_en,
  output logic              out_cpu_hold,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_error
);

  localparam int CNT_W = COUNT_NIBS * NIB_W;
  localparam int MAX_N = 2 ** ADDR_W;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_W-1:0]    data_q, data_d;

  logic                 clr, cnt_clr, shift, csum_en, xfer;
  logic                 ready, busy, done, error, wr, hold;
  logic [WORD_W-1:0]    word_nxt;
  logic [NIB_CNT_W-1:0] nib_cnt;
  logic                 word_complete;
  logic [NIB_W-1:0]     csum;
  logic [CNT_W-1:0]     count_nxt;

  assign xfer      = in_nibble_valid && ready;
  assign count_nxt = word_nxt[CNT_W-1:0];

  nibble_assembler #(
    .WORD_W (WORD_W),
    .NIB_W  (NIB_W)
  ) u_asm (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_i           (clr),
    .cnt_clr_i       (cnt_clr),
    .shift_i         (shift),
    .csum_en_i       (csum_en),
    .nibble_i        (in_nibble),
    .word_nxt_o      (word_nxt),
    .nib_cnt_o       (nib_cnt),
    .word_complete_o (word_complete),
    .csum_o          (csum)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    clr     = 1'b0;
    cnt_clr = 1'b0;
    shift   = 1'b0;
    csum_en = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    wr      = 1'b0;
    hold    = 1'b1;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        done  = (state_q == DONE);
        error = (state_q == ERROR);
        hold  = (state_q != DONE);
        if (in_start) begin
          state_d = COUNT;
          clr     = 1'b1;
          idx_d   = '0;
        end
      end
      COUNT: begin
        ready = 1'b1;
        busy  = 1'b1;
        shift = xfer;
        if (xfer && nib_cnt == NIB_CNT_W'(COUNT_NIBS - 1)) begin
          cnt_clr = 1'b1;
          count_d = count_nxt;
          state_d = (count_nxt == '0 || 32'(count_nxt) > MAX_N) ? ERROR : DATA;
        end
      end
      DATA: begin
        ready   = 1'b1;
        busy    = 1'b1;
        shift   = xfer;
        csum_en = xfer;
        if (word_complete) begin
          state_d = WRITE;
          addr_d  = idx_q[ADDR_W-1:0];
          data_d  = word_nxt;
        end
      end
      WRITE: begin
        busy    = 1'b1;
        wr      = 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == count_q - 1'b1) ? CHECK : DATA;
      end
      CHECK: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (xfer) state_d = (in_nibble == csum) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign out_nibble_ready = ready;
  assign out_code_addr    = addr_q;
  assign out_code_data    = data_q;
  assign out_code_wr_en   = wr;
  assign out_cpu_hold     = hold;
  assign out_busy         = busy;
  assign out_done         = done;
  assign out_error        = error;

endmodule

// File: tb/tb_code_loader.sv
// Randomized bench for code_loader against a list-based model of the expected image and result.
module tb_code_loader;

  localparam int ADDR_W = 9;
  localparam int WORD_W = 16;
  localparam int NIB_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_start = 1'b0;
  logic [NIB_W-1:0]  in_nibble = '0;
  logic              in_nibble_valid = 1'b0;
  logic              out_nibble_ready;
  logic [ADDR_W-1:0] out_code_addr;
  logic [WORD_W-1:0] out_code_data;
  logic              out_code_wr_en;
  logic              out_cpu_hold;
  logic              out_busy;
  logic              out_done;
  logic              out_error;

  int checks = 0;
  int failures = 0;

  logic [15:0] words [512];
  logic [8:0]  wa_q[$];
  logic [15:0] wd_q[$];

  code_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .NIB_W(NIB_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_start         (in_start),
    .in_nibble        (in_nibble),
    .in_nibble_valid  (in_nibble_valid),
    .out_nibble_ready (out_nibble_ready),
    .out_code_addr    (out_code_addr),
    .out_code_data    (out_code_data),
    .out_code_wr_en   (out_code_wr_en),
    .out_cpu_hold     (out_cpu_hold),
    .out_busy         (out_busy),
    .out_done         (out_done),
    .out_error        (out_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_code_wr_en) begin
      wa_q.push_back(out_code_addr);
      wd_q.push_back(out_code_data);
    end
  end

  // Reference: XOR of every data nibble of the first n words.
  function automatic logic [3:0] model_csum(input int n);
    logic [3:0] c = 4'h0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) c ^= words[i][4*k +: 4];
    return c;
  endfunction

  function automatic bit model_count_ok(input logic [11:0] n);
    return (n != 0) && (int'(n) <= 512);
  endfunction

  task automatic send_nib(input logic [3:0] n, input int maxgap, input bit pokes);
    int gap;
    int t;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_nibble_valid = 1'b0;
      in_nibble = 4'($urandom);
      in_start = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    in_start = 1'b0;
    in_nibble = n;
    in_nibble_valid = 1'b1;
    t = 0;
    while (!out_nibble_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 20) begin
      failures++;
      $display("FAIL ready_timeout: ready=%0b after %0d cycles, required 1", out_nibble_ready, t);
    end
    @(posedge clk);
    #1;
    in_nibble_valid = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic do_load(input logic [11:0] n, input logic [3:0] cs, input int maxgap, input bit pokes);
    wa_q.delete();
    wd_q.delete();
    start_pulse();
    for (int i = 2; i >= 0; i--) send_nib(n[4*i +: 4], maxgap, pokes);
    if (model_count_ok(n)) begin
      for (int w = 0; w < int'(n); w++)
        for (int k = 3; k >= 0; k--) send_nib(words[w][4*k +: 4], maxgap, pokes);
      send_nib(cs, maxgap, pokes);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_cpu_hold !== 1'b1 || out_code_wr_en !== 1'b0 || out_nibble_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: hold=%0b wr=%0b ready=%0b, required 1 0 0", out_cpu_hold, out_code_wr_en, out_nibble_ready);
    end
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0 || out_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%0b done=%0b error=%0b, required 0 0 0", out_busy, out_done, out_error);
    end
    checks++;
    if (out_code_addr !== '0 || out_code_data !== '0) begin
      failures++;
      $display("FAIL reset_bus: addr=%0h data=%0h, required 0 0", out_code_addr, out_code_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_busy !== 1'b0 || out_cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%0b hold=%0b, required 0 1", out_busy, out_cpu_hold);
    end
  endtask

  task automatic test_basic_load(input string name, input int maxgap, input bit pokes);
    logic [3:0] cs;
    words[0] = 16'hA1B2;
    words[1] = 16'h0C3D;
    cs = model_csum(2);
    do_load(12'h002, cs, maxgap, pokes);
    checks++;
    if (wa_q.size() != 2) begin
      failures++;
      $display("FAIL %s_write_count: got %0d, required 2", name, wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 9'd0 || wd_q[0] !== 16'hA1B2 || wa_q[1] !== 9'd1 || wd_q[1] !== 16'h0C3D) begin
        failures++;
        $display("FAIL %s_writes: got (%0h,%h) (%0h,%h), required (0,a1b2) (1,0c3d)", name, wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if (out_done !== 1'b1 || out_error !== 1'b0 || out_cpu_hold !== 1'b0 || out_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_result: done=%0b error=%0b hold=%0b busy=%0b, required 1 0 0 0", name, out_done, out_error, out_cpu_hold, out_busy);
    end
  endtask

  task automatic test_bad_count(input string name, input logic [11:0] n);
    do_load(n, 4'h0, 2, 1'b0);
    checks++;
    if (wa_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes: got %0d writes, required 0", name, wa_q.size());
    end
    checks++;
    if (out_error !== 1'b1 || out_done !== 1'b0 || out_cpu_hold !== 1'b1 || out_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_result: error=%0b done=%0b hold=%0b busy=%0b, required 1 0 1 0", name, out_error, out_done, out_cpu_hold, out_busy);
    end
  endtask

  task automatic test_bad_checksum();
    logic [3:0] cs;
    words[0] = 16'hA1B2;
    words[1] = 16'h0C3D;
    cs = model_csum(2) ^ 4'hD;
    do_load(12'h002, cs, 1, 1'b0);
    checks++;
    if (wa_q.size() != 2) begin
      failures++;
      $display("FAIL badcs_write_count: got %0d, required 2", wa_q.size());
    end
    checks++;
    if (out_error !== 1'b1 || out_done !== 1'b0 || out_cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL badcs_result: error=%0b done=%0b hold=%0b, required 1 0 1", out_error, out_done, out_cpu_hold);
    end
  endtask

  task automatic test_max_count();
    int bad;
    for (int i = 0; i < 512; i++) words[i] = 16'($urandom);
    do_load(12'h200, model_csum(512), 0, 1'b0);
    checks++;
    if (wa_q.size() != 512) begin
      failures++;
      $display("FAIL max_write_count: got %0d, required 512", wa_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 512; i++)
        if (int'(wa_q[i]) != i || wd_q[i] !== words[i]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL max_writes: %0d wrong entries, required 0; last addr=%0d", bad, wa_q[511]);
      end
    end
    checks++;
    if (out_done !== 1'b1 || out_cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL max_result: done=%0b hold=%0b, required 1 0", out_done, out_cpu_hold);
    end
  endtask

  task automatic test_random_loads();
    logic [11:0] n;
    logic [3:0]  cs;
    bit          good;
    int          bad;
    for (int r = 0; r < 8; r++) begin
      n = 12'($urandom_range(1, 9));
      for (int i = 0; i < int'(n); i++) words[i] = 16'($urandom);
      good = 1'($urandom_range(0, 1));
      cs = good ? model_csum(int'(n)) : model_csum(int'(n)) ^ 4'($urandom_range(1, 15));
      do_load(n, cs, 3, 1'b1);
      bad = (wa_q.size() != int'(n)) ? 1 : 0;
      if (bad == 0)
        for (int i = 0; i < int'(n); i++)
          if (int'(wa_q[i]) != i || wd_q[i] !== words[i]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand%0d_writes: %0d writes with %0d wrong, required %0d correct", r, wa_q.size(), bad, n);
      end
      checks++;
      if (out_done !== good || out_error !== !good || out_cpu_hold !== !good) begin
        failures++;
        $display("FAIL rand%0d_result: done=%0b error=%0b hold=%0b, required %0b %0b %0b", r, out_done, out_error, out_cpu_hold, good, !good, !good);
      end
    end
  endtask

  task automatic test_reset_midload();
    words[0] = 16'hA1B2;
    words[1] = 16'h0C3D;
    wa_q.delete();
    wd_q.delete();
    start_pulse();
    for (int i = 2; i >= 0; i--) send_nib(4'(12'h002 >> (4*i)), 0, 1'b0);
    for (int k = 3; k >= 0; k--) send_nib(words[0][4*k +: 4], 0, 1'b0);
    for (int k = 3; k >= 2; k--) send_nib(words[1][4*k +: 4], 0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_cpu_hold !== 1'b1 || out_code_wr_en !== 1'b0 || out_busy !== 1'b0 || out_nibble_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: hold=%0b wr=%0b busy=%0b ready=%0b, required 1 0 0 0", out_cpu_hold, out_code_wr_en, out_busy, out_nibble_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() != 1) begin
      failures++;
      $display("FAIL midreset_writes: got %0d writes, required 1", wa_q.size());
    end
    rst_n = 1'b1;
    @(negedge clk);
    test_basic_load("reload", 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_load("basic", 0, 1'b0);
    test_bad_count("zero", 12'h000);
    test_bad_count("over", 12'h201);
    test_bad_count("full", 12'hFFF);
    test_bad_checksum();
    test_max_count();
    test_basic_load("gaps", 5, 1'b1);
    test_random_loads();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
